mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM of the MIPS32 multicycle core. Sequences fetch/decode/execute/memory/writeback,
//  drives IR_W so the instruction register loads exactly once per instruction, and gates PC,
//  memory, register file and ALU muxes. Waits on a memory ready handshake; flags illegal opcodes
//  and memory timeouts.
// PARAMETERS
//  TIMEOUT_CYC  16  max cycles any memory state waits for mem_ready before error (4..255)
// PORTS
//  clk          in   1  single system clock, all state on posedge
//  rst          in   1  asynchronous, active-high reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  zero         in   1  ALU zero flag, sampled in BRANCH
//  mem_ready    in   1  memory completes current access this cycle
//  IR_W         out  1  instruction register write enable
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if zero (BEQ)
//  pc_source    out  2  00 ALU result, 01 ALUOut, 10 jump target
//  iord         out  1  0 address=PC, 1 address=ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  reg_write    out  1  register file write
//  reg_dst      out  1  0 rt, 1 rd
//  mem_to_reg   out  1  0 ALUOut, 1 MDR
//  alu_src_a    out  1  0 PC, 1 rs
//  alu_src_b    out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  alu_op       out  2  00 add, 01 sub, 10 funct-decoded
//  busy         out  1  high while not in FETCH
//  err          out  1  sticky: illegal opcode or memory timeout
// BEHAVIOUR
//  States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JUMP, ADDI_EX,
//   ADDI_WB, HALT. Outputs are Moore (decoded from state, plus mem_ready where noted).
//  Reset (async): state=FETCH, wait counter=0, err=0; all outputs 0 while rst high.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. Hold until mem_ready; in the
//   mem_ready cycle IR_W=1, pc_write=1, pc_source=00 -> DECODE. IR_W is high for exactly one cycle.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next by opcode:
//   0x23 LW / 0x2B SW -> MEM_ADDR; 0x00 R-type -> EXEC_R; 0x04 BEQ -> BRANCH; 0x02 J -> JUMP;
//   0x08 ADDI -> ADDI_EX; other -> HALT with err=1.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: mem_read=1, iord=1; wait for mem_ready -> MEM_WB.
//  MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  MEM_WR: mem_write=1, iord=1; wait for mem_ready -> FETCH.
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB (reg_write=1, reg_dst=1, mem_to_reg=0) -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
//  JUMP: pc_write=1, pc_source=10 -> FETCH.
//  ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0)
//   -> FETCH.
//  HALT: all strobes 0, terminal until rst.
//  Wait counter (8 bit): cleared on entry to FETCH/MEM_RD/MEM_WR, increments each cycle
//   mem_ready=0 in those states. When counter reaches TIMEOUT_CYC with mem_ready still 0:
//   err=1, -> HALT, no IR_W/pc_write/reg_write issued.
//   mem_ready in the same cycle as the limit wins (normal progress).
//  mem_ready is ignored in all non-memory states. mem_read and mem_write never both high.
//  rst asserted mid-instruction aborts immediately; no partial writeback occurs after release.
//  Latency with mem_ready=1 same cycle: R/ADDI 4, LW 5, SW 4, BEQ/J 3 cycles.
// TESTING
//  rst pulse mid-MEM_RD -> outputs 0 during rst; first cycle after release in FETCH, err=0.
//  R-type (op 0x00), mem_ready=1 always -> IR_W 1 cycle at cycle 0, reg_write+reg_dst at cycle 3,
//   busy low at cycle 4.
//  LW with mem_ready delayed 3 cycles in MEM_RD -> mem_read/iord held 4 cycles, then MEM_WB
//   mem_to_reg=1.
//  BEQ with zero=1 and zero=0 -> pc_write_cond=1, pc_source=01 in cycle 2 both cases; J ->
//   pc_write=1, pc_source=10.
//  opcode 0x3F -> HALT, err=1 sticky, no further IR_W until rst.
//  mem_ready held 0 in FETCH, TIMEOUT_CYC=4 -> err=1 after 4 wait cycles; mem_ready on 4th
//   cycle -> normal DECODE.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller owns the master side; the datapath/memory owns the slave side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       IR_W;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       busy;
  logic       err;

  modport master (
    input  opcode, zero, mem_ready,
    output IR_W, pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, busy, err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  IR_W, pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, busy, err
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the MIPS32 multicycle core: Moore-decoded datapath strobes,
// memory ready handshake with a per-state wait timeout, sticky error on illegal opcode/timeout.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input logic                    clk,
  input logic                    rst,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // The N-th consecutive not-ready cycle (counter == N-1) is the one that times out,
  // unless mem_ready arrives in that same cycle.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYC - 1);

  logic [3:0] r_state;
  logic [3:0] w_nextState;
  logic [7:0] r_waitCnt;
  logic       r_err;
  logic       r_isStore;
  logic       w_memState;
  logic       w_timeout;
  logic       w_illegal;

  logic       w_irW;
  logic       w_pcWrite;
  logic       w_pcWriteCond;
  logic [1:0] w_pcSource;
  logic       w_iord;
  logic       w_memRead;
  logic       w_memWrite;
  logic       w_regWrite;
  logic       w_regDst;
  logic       w_memToReg;
  logic       w_aluSrcA;
  logic [1:0] w_aluSrcB;
  logic [1:0] w_aluOp;
  logic       w_busy;

  assign w_memState = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout  = w_memState && !bus.mem_ready && (r_waitCnt == WAIT_LIMIT);

  always_comb begin
    w_nextState = r_state;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready)  w_nextState = S_DECODE;
        else if (w_timeout) w_nextState = S_HALT;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_nextState = S_MEM_ADDR;
          OP_RTYPE:     w_nextState = S_EXEC_R;
          OP_BEQ:       w_nextState = S_BRANCH;
          OP_J:         w_nextState = S_JUMP;
          OP_ADDI:      w_nextState = S_ADDI_EX;
          default: begin
            w_nextState = S_HALT;
            w_illegal   = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: w_nextState = r_isStore ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready)  w_nextState = S_MEM_WB;
        else if (w_timeout) w_nextState = S_HALT;
      end
      S_MEM_WB:  w_nextState = S_FETCH;
      S_MEM_WR: begin
        if (bus.mem_ready)  w_nextState = S_FETCH;
        else if (w_timeout) w_nextState = S_HALT;
      end
      S_EXEC_R:  w_nextState = S_R_WB;
      S_R_WB:    w_nextState = S_FETCH;
      S_BRANCH:  w_nextState = S_FETCH;
      S_JUMP:    w_nextState = S_FETCH;
      S_ADDI_EX: w_nextState = S_ADDI_WB;
      S_ADDI_WB: w_nextState = S_FETCH;
      S_HALT:    w_nextState = S_HALT;
      default:   w_nextState = S_HALT;
    endcase
  end

  // The wait counter restarts on every state change, so each memory state begins at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_waitCnt <= '0;
      r_err     <= 1'b0;
      r_isStore <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state)
        r_waitCnt <= '0;
      else if (w_memState && !bus.mem_ready)
        r_waitCnt <= r_waitCnt + 8'd1;
      if (w_timeout || w_illegal)
        r_err <= 1'b1;
      if (r_state == S_DECODE)
        r_isStore <= (bus.opcode == OP_SW);
    end
  end

  always_comb begin
    w_irW         = 1'b0;
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_pcSource    = 2'b00;
    w_iord        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_regWrite    = 1'b0;
    w_regDst      = 1'b0;
    w_memToReg    = 1'b0;
    w_aluSrcA     = 1'b0;
    w_aluSrcB     = 2'b00;
    w_aluOp       = 2'b00;
    w_busy        = 1'b0;
    if (!rst) begin
      w_busy = (r_state != S_FETCH);
      case (r_state)
        S_FETCH: begin
          w_memRead = 1'b1;
          w_aluSrcB = 2'b01;
          w_irW     = bus.mem_ready;
          w_pcWrite = bus.mem_ready;
        end
        S_DECODE:   w_aluSrcB = 2'b11;
        S_MEM_ADDR: begin
          w_aluSrcA = 1'b1;
          w_aluSrcB = 2'b10;
        end
        S_MEM_RD: begin
          w_memRead = 1'b1;
          w_iord    = 1'b1;
        end
        S_MEM_WB: begin
          w_regWrite = 1'b1;
          w_memToReg = 1'b1;
        end
        S_MEM_WR: begin
          w_memWrite = 1'b1;
          w_iord     = 1'b1;
        end
        S_EXEC_R: begin
          w_aluSrcA = 1'b1;
          w_aluOp   = 2'b10;
        end
        S_R_WB: begin
          w_regWrite = 1'b1;
          w_regDst   = 1'b1;
        end
        S_BRANCH: begin
          w_aluSrcA     = 1'b1;
          w_aluOp       = 2'b01;
          w_pcWriteCond = 1'b1;
          w_pcSource    = 2'b01;
        end
        S_JUMP: begin
          w_pcWrite  = 1'b1;
          w_pcSource = 2'b10;
        end
        S_ADDI_EX: begin
          w_aluSrcA = 1'b1;
          w_aluSrcB = 2'b10;
        end
        S_ADDI_WB: w_regWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.IR_W          = w_irW;
  assign bus.pc_write      = w_pcWrite;
  assign bus.pc_write_cond = w_pcWriteCond;
  assign bus.pc_source     = w_pcSource;
  assign bus.iord          = w_iord;
  assign bus.mem_read      = w_memRead;
  assign bus.mem_write     = w_memWrite;
  assign bus.reg_write     = w_regWrite;
  assign bus.reg_dst       = w_regDst;
  assign bus.mem_to_reg    = w_memToReg;
  assign bus.alu_src_a     = w_aluSrcA;
  assign bus.alu_src_b     = w_aluSrcB;
  assign bus.alu_op        = w_aluOp;
  assign bus.busy          = w_busy;
  assign bus.err           = r_err;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl (TIMEOUT_CYC=4): each stimulus cycle queues the
// hand-derived expected strobes, and a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       irW;
    logic       pcWrite;
    logic       pcWriteCond;
    logic [1:0] pcSource;
    logic       iord;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       busy;
    logic       err;
  } outs_t;

  localparam int ST_RST     = 0;
  localparam int ST_FETCH   = 1;
  localparam int ST_DECODE  = 2;
  localparam int ST_MEMADDR = 3;
  localparam int ST_MEMRD   = 4;
  localparam int ST_MEMWB   = 5;
  localparam int ST_MEMWR   = 6;
  localparam int ST_EXECR   = 7;
  localparam int ST_RWB     = 8;
  localparam int ST_BRANCH  = 9;
  localparam int ST_JUMP    = 10;
  localparam int ST_ADDIEX  = 11;
  localparam int ST_ADDIWB  = 12;
  localparam int ST_HALT    = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared = 0;
  int   nMismatched = 0;
  outs_t expQ[$];
  string nameQ[$];

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected strobes for a state, taken straight from the controller's output table.
  function automatic outs_t expOut(input int st, input logic mr, input logic e);
    outs_t o;
    o = '0;
    case (st)
      ST_FETCH:   begin o.memRead = 1'b1; o.aluSrcB = 2'b01; o.irW = mr; o.pcWrite = mr; end
      ST_DECODE:  o.aluSrcB = 2'b11;
      ST_MEMADDR: begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; end
      ST_MEMRD:   begin o.memRead = 1'b1; o.iord = 1'b1; end
      ST_MEMWB:   begin o.regWrite = 1'b1; o.memToReg = 1'b1; end
      ST_MEMWR:   begin o.memWrite = 1'b1; o.iord = 1'b1; end
      ST_EXECR:   begin o.aluSrcA = 1'b1; o.aluOp = 2'b10; end
      ST_RWB:     begin o.regWrite = 1'b1; o.regDst = 1'b1; end
      ST_BRANCH:  begin o.aluSrcA = 1'b1; o.aluOp = 2'b01; o.pcWriteCond = 1'b1; o.pcSource = 2'b01; end
      ST_JUMP:    begin o.pcWrite = 1'b1; o.pcSource = 2'b10; end
      ST_ADDIEX:  begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; end
      ST_ADDIWB:  o.regWrite = 1'b1;
      default: ;
    endcase
    o.busy = (st != ST_FETCH) && (st != ST_RST);
    o.err  = (st == ST_RST) ? 1'b0 : e;
    return o;
  endfunction

  task automatic applyStimulus(input string name, input logic r, input logic [5:0] op,
                               input logic z, input logic mr, input int st, input logic e);
    @(posedge clk);
    #1;
    rst           = r;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    expQ.push_back(expOut(st, mr, e));
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = {bus.IR_W, bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord, bus.mem_read,
           bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
           bus.alu_src_b, bus.alu_op, bus.busy, bus.err};
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %b expected %b (irW pcW pcWC pcSrc iord mRd mWr regW regDst m2r srcA srcB op busy err)",
               name, act, exp);
    end
  endtask

  initial begin : monitor
    outs_t e;
    string n;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, e);
      end
    end
  end

  initial begin : stimulus
    bus.opcode    = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    applyStimulus("reset0", 1, 6'h00, 0, 1, ST_RST, 0);
    applyStimulus("reset1", 1, 6'h00, 0, 1, ST_RST, 0);

    // R-type, memory always ready
    applyStimulus("r_fetch",  0, 6'h00, 0, 1, ST_FETCH,  0);
    applyStimulus("r_decode", 0, 6'h00, 0, 1, ST_DECODE, 0);
    applyStimulus("r_exec",   0, 6'h00, 0, 1, ST_EXECR,  0);
    applyStimulus("r_wb",     0, 6'h00, 0, 1, ST_RWB,    0);

    // LW with three not-ready cycles in MEM_RD (ready lands on the limit cycle)
    applyStimulus("lw_fetch",  0, 6'h23, 0, 1, ST_FETCH,   0);
    applyStimulus("lw_decode", 0, 6'h23, 0, 1, ST_DECODE,  0);
    applyStimulus("lw_addr",   0, 6'h23, 0, 1, ST_MEMADDR, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("lw_rd_wait", 0, 6'h23, 0, 0, ST_MEMRD, 0);
    applyStimulus("lw_rd_done", 0, 6'h23, 0, 1, ST_MEMRD, 0);
    applyStimulus("lw_wb",      0, 6'h23, 0, 1, ST_MEMWB, 0);

    // SW
    applyStimulus("sw_fetch",  0, 6'h2B, 0, 1, ST_FETCH,   0);
    applyStimulus("sw_decode", 0, 6'h2B, 0, 1, ST_DECODE,  0);
    applyStimulus("sw_addr",   0, 6'h2B, 0, 1, ST_MEMADDR, 0);
    applyStimulus("sw_wr",     0, 6'h2B, 0, 1, ST_MEMWR,   0);

    // BEQ taken and not taken look identical to the controller
    applyStimulus("beq1_fetch",  0, 6'h04, 1, 1, ST_FETCH,  0);
    applyStimulus("beq1_decode", 0, 6'h04, 1, 1, ST_DECODE, 0);
    applyStimulus("beq1_branch", 0, 6'h04, 1, 1, ST_BRANCH, 0);
    applyStimulus("beq0_fetch",  0, 6'h04, 0, 1, ST_FETCH,  0);
    applyStimulus("beq0_decode", 0, 6'h04, 0, 1, ST_DECODE, 0);
    applyStimulus("beq0_branch", 0, 6'h04, 0, 1, ST_BRANCH, 0);

    // J
    applyStimulus("j_fetch",  0, 6'h02, 0, 1, ST_FETCH,  0);
    applyStimulus("j_decode", 0, 6'h02, 0, 1, ST_DECODE, 0);
    applyStimulus("j_jump",   0, 6'h02, 0, 1, ST_JUMP,   0);

    // ADDI
    applyStimulus("addi_fetch",  0, 6'h08, 0, 1, ST_FETCH,  0);
    applyStimulus("addi_decode", 0, 6'h08, 0, 1, ST_DECODE, 0);
    applyStimulus("addi_ex",     0, 6'h08, 0, 1, ST_ADDIEX, 0);
    applyStimulus("addi_wb",     0, 6'h08, 0, 1, ST_ADDIWB, 0);

    // FETCH: ready on the 4th wait cycle still proceeds normally
    for (int i = 0; i < 3; i++)
      applyStimulus("fetch_wait", 0, 6'h02, 0, 0, ST_FETCH, 0);
    applyStimulus("fetch_edge_ok", 0, 6'h02, 0, 1, ST_FETCH,  0);
    applyStimulus("edge_decode",   0, 6'h02, 0, 1, ST_DECODE, 0);
    applyStimulus("edge_jump",     0, 6'h02, 0, 1, ST_JUMP,   0);

    // Reset in the middle of MEM_RD, then an R-type runs cleanly
    applyStimulus("mid_fetch",  0, 6'h23, 0, 1, ST_FETCH,   0);
    applyStimulus("mid_decode", 0, 6'h23, 0, 1, ST_DECODE,  0);
    applyStimulus("mid_addr",   0, 6'h23, 0, 1, ST_MEMADDR, 0);
    applyStimulus("mid_rd",     0, 6'h23, 0, 0, ST_MEMRD,   0);
    applyStimulus("mid_rst0",   1, 6'h23, 0, 1, ST_RST,     0);
    applyStimulus("mid_rst1",   1, 6'h23, 0, 1, ST_RST,     0);
    applyStimulus("post_fetch_wait", 0, 6'h00, 0, 0, ST_FETCH, 0);
    applyStimulus("post_fetch",  0, 6'h00, 0, 1, ST_FETCH,  0);
    applyStimulus("post_decode", 0, 6'h00, 0, 1, ST_DECODE, 0);
    applyStimulus("post_exec",   0, 6'h00, 0, 1, ST_EXECR,  0);
    applyStimulus("post_wb",     0, 6'h00, 0, 1, ST_RWB,    0);

    // FETCH timeout: four not-ready cycles -> HALT with sticky err
    for (int i = 0; i < 4; i++)
      applyStimulus("fetch_to_wait", 0, 6'h00, 0, 0, ST_FETCH, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("fetch_to_halt", 0, 6'h00, 0, 1, ST_HALT, 1);

    // Illegal opcode
    applyStimulus("ill_rst",    1, 6'h3F, 0, 1, ST_RST,    0);
    applyStimulus("ill_fetch",  0, 6'h3F, 0, 1, ST_FETCH,  0);
    applyStimulus("ill_decode", 0, 6'h3F, 0, 1, ST_DECODE, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("ill_halt", 0, 6'h3F, 0, 1, ST_HALT, 1);

    // MEM_RD timeout: no writeback is issued
    applyStimulus("rdto_rst",    1, 6'h23, 0, 1, ST_RST,     0);
    applyStimulus("rdto_fetch",  0, 6'h23, 0, 1, ST_FETCH,   0);
    applyStimulus("rdto_decode", 0, 6'h23, 0, 1, ST_DECODE,  0);
    applyStimulus("rdto_addr",   0, 6'h23, 0, 1, ST_MEMADDR, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("rdto_wait", 0, 6'h23, 0, 0, ST_MEMRD, 0);
    applyStimulus("rdto_halt0", 0, 6'h23, 0, 1, ST_HALT, 1);
    applyStimulus("rdto_halt1", 0, 6'h23, 0, 1, ST_HALT, 1);

    applyStimulus("final_rst",   1, 6'h00, 0, 0, ST_RST,   0);
    applyStimulus("final_fetch", 0, 6'h00, 0, 0, ST_FETCH, 0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++)
      @(posedge clk);
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
